yarp_decode_pipe: RTL and testbench
===================================

# yarp_decode_pipe

Registered, parametrised instruction-decode stage for the YARP core. It sits between fetch and execute and decodes RV32I/RV64I base-encoding fields, immediate and instruction type in one cycle. Results are held in a 2-entry skid buffer with valid/ready handshakes on both sides. It also flags illegal encodings, supports pipeline flush, and counts retired decodes.

## Interface
Parameters:
- XLEN, 32 — datapath width, 32 or 64; immediates sign-extend to XLEN
- CNT_W, 32 — width of the decoded-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  drop all buffered and incoming instructions
- in_valid_i  in  1  fetch has an instruction
- in_ready_o  out  1  stage can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- out_valid_o  out  1  decoded entry valid
- out_ready_i  in  1  execute accepts
- pc_o  out  XLEN  PC of output entry
- rs1_o, rs2_o, rd_o  out  5 each  register indices
- op_o  out  7  opcode
- funct3_o  out  3  funct3
- funct7_o  out  7  funct7
- type_o  out  6  one-hot {j,u,b,s,i,r}
- illegal_o  out  1  unrecognised encoding
- imm_o  out  XLEN  sign-extended immediate
- dec_count_o  out  CNT_W  saturating count of output handshakes

## Operation
- Opcode map:
  - R = 0x33
  - I = 0x03, 0x13, 0x67
  - S = 0x23
  - B = 0x63
  - U = 0x37, 0x17
  - J = 0x6F
- Illegal: any other opcode, or instr[1:0] != 2'b11. Sets illegal_o=1, type_o=0, imm_o=0. The entry still flows through the handshake.
- Immediates, sign bit instr[31] extended to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'h0}, sign-extended from bit 31 when XLEN=64
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm_o = 0
- Field outputs (rs1/rs2/rd/op/funct3/funct7) come straight from instruction bits regardless of type.
- Buffer structure:
  - Main entry drives the outputs.
  - Skid entry holds one extra decoded instruction.
  - in_ready_o = !skid_valid, a registered signal with no combinational path from out_ready_i.
- Per-cycle behaviour, with in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i:
  - Main empty, or out_fire with skid empty: an in_fire loads main.
  - out_fire with skid full: skid moves to main. in_ready_o is 0 that cycle, so no load occurs.
  - Main full, no out_fire, in_fire: load skid.
- Ordering is strictly FIFO.
- Flush: when flush_i=1, main and skid valids clear next cycle and any same-cycle in_fire is discarded. flush_i has priority over every other event. dec_count_o still counts a same-cycle out_fire.
- Counter: increments by 1 on each out_fire and saturates at 2^CNT_W−1. Flush does not clear it; only reset does.

## Timing
- Latency: 1 cycle from in_fire to out_valid_o.
- Throughput: 1 instruction per cycle while out_ready_i stays high.
- Backpressure: after out_ready_i falls, at most one further instruction is accepted (into skid), then in_ready_o=0 the next cycle.
- Stability: output fields are stable while out_valid_o=1 and out_ready_i=0.
- Reset: all outputs are 0 one cycle after reset is sampled high, except in_ready_o, which is 1. Reset mid-stream discards both entries.
- When out_valid_o=0, output data fields are don't-care. The implementation holds their last values.

## Test plan
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle: out_valid=1, type_o=6'b000010, rd=1, rs1=0, imm_o=0xFFFFFFFF.
- Decode 0x00112223 (sw x1,4(x2)) → type_o=6'b000100, rs1=2, rs2=1, funct3=2, imm_o=4. Then decode 0xFFDFF06F (jal x0,-4) → type_o=6'b100000, imm_o=0xFFFFFFFC.
- XLEN=64, 0x800002B7 (lui x5) → imm_o=0xFFFFFFFF80000000, rd=5. Then 0xFFDFF06F → imm_o=0xFFFFFFFFFFFFFFFC.
- Instr 0x0000007F and instr 0x00000013 with bits[1:0] forced to 00 → illegal_o=1, type_o=0, imm_o=0, each delivered in order.
- Stream of 4 instructions, out_ready low for 3 cycles mid-stream → exactly one entry lands in skid, in_ready_o drops, all 4 emerge in order, dec_count_o=4.
- Flush asserted with main and skid full plus in_valid high → next cycle out_valid=0, in_ready=1, no flushed instruction ever appears. With CNT_W=2, 5 handshakes → dec_count_o saturates at 3.

Source files
------------

// File: rtl/yarp_decode_pipe.sv
// YARP instruction-decode stage: one-cycle RV32I/RV64I field and immediate decode
// feeding a two-entry (main + skid) valid/ready buffer with flush and a retire counter.
module yarp_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [6:0]       op_o,
  output logic [2:0]       funct3_o,
  output logic [6:0]       funct7_o,
  output logic [5:0]       type_o,
  output logic             illegal_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [CNT_W-1:0] dec_count_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [5:0]      typ;
    logic            illegal;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs2;
    logic [4:0]      rs1;
  } dec_t;

  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  // Every immediate is first formed as a signed 32-bit value, so widening to
  // XLEN=64 replicates bit 31 (this is also what makes U-type sign-extend).
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic signed [XLEN-1:0] w;
    w = XLEN'(v);
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic dec_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    dec_t               d;
    logic signed [31:0] imm32;
    logic [5:0]         typ;
    typ   = '0;
    imm32 = '0;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h33: typ = T_R;
        7'h03, 7'h13, 7'h67: begin
          typ   = T_I;
          imm32 = {{20{ins[31]}}, ins[31:20]};
        end
        7'h23: begin
          typ   = T_S;
          imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end
        7'h63: begin
          typ   = T_B;
          imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'h37, 7'h17: begin
          typ   = T_U;
          imm32 = {ins[31:12], 12'h000};
        end
        7'h6F: begin
          typ   = T_J;
          imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        default: typ = '0;
      endcase
    end
    d.pc      = pc;
    d.imm     = sext32(imm32);
    d.typ     = typ;
    d.illegal = (typ == '0);
    d.funct7  = ins[31:25];
    d.funct3  = ins[14:12];
    d.op      = ins[6:0];
    d.rd      = ins[11:7];
    d.rs2     = ins[24:20];
    d.rs1     = ins[19:15];
    return d;
  endfunction

  // ---- stage p0: combinational decode of the incoming word ----
  dec_t dec_p0;
  always_comb dec_p0 = decode(instr_i, pc_i);

  // ---- stage p1: main (output) entry and skid entry ----
  dec_t             main_p1;
  dec_t             skid_p1;
  logic             vld_p1;
  logic             skid_vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             in_fire;
  logic             out_fire;
  logic             main_free;

  assign in_ready_o = !skid_vld_p1;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = vld_p1 & out_ready_i;
  assign main_free  = !vld_p1 | out_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      cnt_p1      <= '0;
    end else begin
      if (out_fire) cnt_p1 <= sat_inc(cnt_p1);
      if (flush_i) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
      end else if (main_free) begin
        // A full skid always drains first; in_ready is low then, so no load collides.
        if (skid_vld_p1) begin
          main_p1     <= skid_p1;
          vld_p1      <= 1'b1;
          skid_vld_p1 <= 1'b0;
        end else if (in_fire) begin
          main_p1 <= dec_p0;
          vld_p1  <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (in_fire) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Skid payload is qualified by skid_vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!flush_i && !main_free && in_fire) skid_p1 <= dec_p0;
  end

  assign out_valid_o = vld_p1;
  assign pc_o        = main_p1.pc;
  assign rs1_o       = main_p1.rs1;
  assign rs2_o       = main_p1.rs2;
  assign rd_o        = main_p1.rd;
  assign op_o        = main_p1.op;
  assign funct3_o    = main_p1.funct3;
  assign funct7_o    = main_p1.funct7;
  assign type_o      = main_p1.typ;
  assign illegal_o   = main_p1.illegal;
  assign imm_o       = main_p1.imm;
  assign dec_count_o = cnt_p1;

endmodule

// File: tb/tb_yarp_decode_pipe.sv
// Bench for yarp_decode_pipe: XLEN=32, XLEN=64 and CNT_W=2 instances share one stimulus
// stream; a queue scoreboard checks every output handshake against hand-computed vectors.
module tb_yarp_decode_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        r32_in_ready, r32_out_valid, r32_ill;
  logic [31:0] r32_pc, r32_imm, r32_cnt;
  logic [4:0]  r32_rs1, r32_rs2, r32_rd;
  logic [6:0]  r32_op, r32_f7;
  logic [2:0]  r32_f3;
  logic [5:0]  r32_type;

  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [63:0] r64_pc, r64_imm;
  logic [31:0] r64_cnt;
  logic [4:0]  r64_rs1, r64_rs2, r64_rd;
  logic [6:0]  r64_op, r64_f7;
  logic [2:0]  r64_f3;
  logic [5:0]  r64_type;

  logic        c2_in_ready, c2_out_valid, c2_ill;
  logic [31:0] c2_pc, c2_imm;
  logic [1:0]  c2_cnt;
  logic [4:0]  c2_rs1, c2_rs2, c2_rd;
  logic [6:0]  c2_op, c2_f7;
  logic [2:0]  c2_f3;
  logic [5:0]  c2_type;

  yarp_decode_pipe #(.XLEN(32), .CNT_W(32)) u32 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32_in_ready),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(r32_out_valid), .out_ready_i(out_ready),
    .pc_o(r32_pc), .rs1_o(r32_rs1), .rs2_o(r32_rs2), .rd_o(r32_rd), .op_o(r32_op),
    .funct3_o(r32_f3), .funct7_o(r32_f7), .type_o(r32_type), .illegal_o(r32_ill),
    .imm_o(r32_imm), .dec_count_o(r32_cnt));

  yarp_decode_pipe #(.XLEN(64), .CNT_W(32)) u64 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64_in_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(r64_out_valid), .out_ready_i(out_ready),
    .pc_o(r64_pc), .rs1_o(r64_rs1), .rs2_o(r64_rs2), .rd_o(r64_rd), .op_o(r64_op),
    .funct3_o(r64_f3), .funct7_o(r64_f7), .type_o(r64_type), .illegal_o(r64_ill),
    .imm_o(r64_imm), .dec_count_o(r64_cnt));

  yarp_decode_pipe #(.XLEN(32), .CNT_W(2)) uc2 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(c2_in_ready),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(c2_out_valid), .out_ready_i(out_ready),
    .pc_o(c2_pc), .rs1_o(c2_rs1), .rs2_o(c2_rs2), .rd_o(c2_rd), .op_o(c2_op),
    .funct3_o(c2_f3), .funct7_o(c2_f7), .type_o(c2_type), .illegal_o(c2_ill),
    .imm_o(c2_imm), .dec_count_o(c2_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  typ;
    logic        ill;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [63:0] pc;
  } exp_t;

  vec_t        tbl [9];
  exp_t        q [$];
  exp_t        cur;
  logic [63:0] pc_next;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake, push on every accepted input.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (r32_out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc 0x%0h, expected no output", r32_pc);
        end else begin
          e = q.pop_front();
          check("pc32",     64'(r32_pc),   64'(e.pc[31:0]));
          check("type",     64'(r32_type), 64'(e.v.typ));
          check("illegal",  64'(r32_ill),  64'(e.v.ill));
          check("imm32",    64'(r32_imm),  64'(e.v.imm[31:0]));
          check("rd",       64'(r32_rd),   64'(e.v.rd));
          check("rs1",      64'(r32_rs1),  64'(e.v.rs1));
          check("rs2",      64'(r32_rs2),  64'(e.v.rs2));
          check("funct3",   64'(r32_f3),   64'(e.v.f3));
          check("op",       64'(r32_op),   64'(e.v.instr[6:0]));
          check("funct7",   64'(r32_f7),   64'(e.v.instr[31:25]));
          check("valid64",  64'(r64_out_valid), 64'd1);
          check("imm64",    r64_imm,       e.v.imm);
          check("pc64",     r64_pc,        e.pc);
          check("type64",   64'(r64_type), 64'(e.v.typ));
          check("valid_c2", 64'(c2_out_valid), 64'd1);
        end
      end
      if (flush) q.delete();
      else if (in_valid && r32_in_ready) q.push_back(cur);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word has been accepted.
  task automatic send(input vec_t v);
    int t;
    bit acc;
    instr    = v.instr;
    pc       = pc_next;
    in_valid = 1'b1;
    cur.v    = v;
    cur.pc   = pc_next;
    pc_next  = pc_next + 64'd4;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = r32_in_ready && !flush;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  int   stall_cycles;
  logic held;
  logic [31:0] hold_pc, hold_imm;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pc_next  = 64'hFFFF_FFF0_0000_1000;
    //            instr          type       ill   imm                     rd  rs1 rs2 f3
    tbl[0] = '{32'hFFF00093, 6'b000010, 1'b0, 64'hFFFFFFFFFFFFFFFF,  1,  0, 31, 0};
    tbl[1] = '{32'h00112223, 6'b000100, 1'b0, 64'h0000000000000004,  4,  2,  1, 2};
    tbl[2] = '{32'hFFDFF06F, 6'b100000, 1'b0, 64'hFFFFFFFFFFFFFFFC,  0, 31, 29, 7};
    tbl[3] = '{32'h800002B7, 6'b010000, 1'b0, 64'hFFFFFFFF80000000,  5,  0,  0, 0};
    tbl[4] = '{32'h0000007F, 6'b000000, 1'b1, 64'h0000000000000000,  0,  0,  0, 0};
    tbl[5] = '{32'h00000010, 6'b000000, 1'b1, 64'h0000000000000000,  0,  0,  0, 0};
    tbl[6] = '{32'h002081B3, 6'b000001, 1'b0, 64'h0000000000000000,  3,  1,  2, 0};
    tbl[7] = '{32'hFE208CE3, 6'b001000, 1'b0, 64'hFFFFFFFFFFFFFFF8, 25,  1,  2, 0};
    tbl[8] = '{32'h00001017, 6'b010000, 1'b0, 64'h0000000000001000,  0,  0,  0, 1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 64'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(r32_out_valid), 64'd0);
    check("rst_in_ready",  64'(r32_in_ready),  64'd1);
    check("rst_count",     64'(r32_cnt),       64'd0);
    check("rst_fields",    64'({r32_pc, r32_imm}), 64'd0);
    check("rst_type_ill",  64'({r32_type, r32_ill, r32_rd, r32_rs1, r32_rs2}), 64'd0);
    check("rst_imm64",     r64_imm, 64'd0);

    // Back-to-back decode of the whole table at full throughput.
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send(tbl[i]);
    in_valid = 1'b0;
    drain();
    check("count_after_table", 64'(r32_cnt), 64'd9);
    check("count_sat_cnt2",    64'(c2_cnt),  64'd3);

    // Four-word stream with out_ready low for three cycles mid-stream.
    @(posedge clk); #1;
    stall_cycles = 0;
    held = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!r32_in_ready) stall_cycles++;
          if (r32_out_valid && !out_ready) begin
            if (held) begin
              check("hold_pc",  64'(r32_pc),  64'(hold_pc));
              check("hold_imm", 64'(r32_imm), 64'(hold_imm));
            end
            hold_pc  = r32_pc;
            hold_imm = r32_imm;
            held     = 1'b1;
          end else begin
            held = 1'b0;
          end
        end
      end
    join
    drain();
    check("stall_cycles",        64'(stall_cycles), 64'd3);
    check("count_after_stream",  64'(r32_cnt),      64'd13);

    // Fill main and skid, then flush with a new word offered the same cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(tbl[6]);
    send(tbl[7]);
    check("skid_full_ready", 64'(r32_in_ready), 64'd0);
    instr    = tbl[8].instr;
    pc       = pc_next;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(r32_out_valid), 64'd0);
    check("flush_in_ready",  64'(r32_in_ready),  64'd1);
    check("flush_queue",     64'(q.size()),      64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    pc_next   = pc_next + 64'h100;
    send(tbl[1]);
    in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("final_count",    64'(r32_cnt), 64'd14);
    check("final_count64",  64'(r64_cnt), 64'd14);
    check("final_count_c2", 64'(c2_cnt),  64'd3);
    check("final_idle",     64'(r32_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
